// File: rtl/da_rom_loader.sv
// -----------------------------------------------------------------------------
// da_rom_loader
//
// Purpose:
//   Holds the 64 FIR coefficients of the distributed-arithmetic filter and, on
//   request, generates the eight 256-entry partial-sum ROM images from them,
//   streaming all 2048 entries into the downstream 'da' load port at one entry
//   per clock. Entry (r, a) is the sum of the coefficients of tap group r
//   (coef[8r+0] .. coef[8r+7]) whose bit position is set in address a.
//
// Ports:
//   clk         single clock
//   resetn      asynchronous, active-low reset
//   coef_in     signed coefficient write data
//   coef_addr   coefficient index k: tap group k[5:3], bit position k[2:0]
//   coef_we     coefficient write strobe, honoured only while idle
//   load_start  single-cycle request to generate and stream all tables
//   abort       cancels a stream in progress (no done pulse)
//   busy        high while stream activity is on the outputs
//   done        one-cycle pulse after the last entry of a complete stream
//   caddr       {rom index r[2:0], entry address a[7:0]} to da CADDR
//   cin         signed table entry to da CIN
//   cload       entry strobe to da CLOAD
//   cvalid      copy of cload for da valid_in
// -----------------------------------------------------------------------------
module da_rom_loader #(
  parameter int COEF_W = 16,
  parameter int OUT_W  = 20
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic signed [COEF_W-1:0] coef_in,
  input  logic [5:0]               coef_addr,
  input  logic                     coef_we,
  input  logic                     load_start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic [10:0]              caddr,
  output logic signed [OUT_W-1:0]  cin,
  output logic                     cload,
  output logic                     cvalid
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DONE
  } state_e;

  localparam logic [10:0] LAST_ENTRY = 11'd2047;

  state_e                  state_q, state_d;
  logic [10:0]             cnt_q, cnt_d;
  logic signed [COEF_W-1:0] coef_q [64];

  logic [10:0]             caddr_q, caddr_d;
  logic signed [OUT_W-1:0] cin_q, cin_d;
  logic                    cload_q, cload_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;

  logic [2:0]              rom_sel;
  logic [7:0]              ent_addr;
  logic signed [OUT_W-1:0] term [8];
  logic signed [OUT_W-1:0] lvl1 [4];
  logic signed [OUT_W-1:0] lvl2 [2];
  logic signed [OUT_W-1:0] entry_sum;

  assign rom_sel  = cnt_q[10:8];
  assign ent_addr = cnt_q[7:0];

  // Coefficient bank. Writes are only accepted while idle so that a stream
  // always reflects one consistent coefficient set; a write coinciding with
  // load_start lands on that same edge and is therefore seen by every entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 64; k++) begin
        coef_q[k] <= '0;
      end
    end else if (state_q == ST_IDLE && coef_we) begin
      coef_q[coef_addr] <= coef_in;
    end
  end

  // Select the sign-extended coefficients of the current tap group that are
  // enabled by the address bits. Unselected taps contribute zero, so address
  // 0 naturally yields 0.
  always_comb begin
    for (int b = 0; b < 8; b++) begin
      term[b] = '0;
      if (ent_addr[b]) begin
        term[b] = {{(OUT_W-COEF_W){coef_q[{rom_sel, 3'(b)}][COEF_W-1]}},
                   coef_q[{rom_sel, 3'(b)}]};
      end
    end
  end

  // Balanced adder tree over the eight selected terms. Eight full-scale
  // 16-bit values sum to at most 2^18 in magnitude, so a 20-bit result never
  // overflows and no saturation is needed.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lvl1[i] = term[2*i] + term[2*i+1];
    end
    for (int i = 0; i < 2; i++) begin
      lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
    end
    entry_sum = lvl2[0] + lvl2[1];
  end

  // State, entry counter and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      caddr_q <= '0;
      cin_q   <= '0;
      cload_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      caddr_q <= caddr_d;
      cin_q   <= cin_d;
      cload_q <= cload_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and output decode. Outputs default to zero so caddr/cin are
  // held at 0 whenever no entry is being presented. busy is registered
  // alongside the other outputs: it rises with the first entry and falls
  // together with the done pulse, or at the same edge an abort clears cload.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    caddr_d = '0;
    cin_d   = '0;
    cload_d = 1'b0;
    done_d  = 1'b0;
    busy_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_STREAM;
          cnt_d   = '0;
        end
      end
      ST_STREAM: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          caddr_d = cnt_q;
          cin_d   = entry_sum;
          cload_d = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = cnt_q + 11'd1;
          if (cnt_q == LAST_ENTRY) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!abort) begin
          done_d = 1'b1;
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign caddr  = caddr_q;
  assign cin    = cin_q;
  assign cload  = cload_q;
  assign cvalid = cload_q;

endmodule

// File: tb/tb_da_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_da_rom_loader
//
// Self-checking bench for da_rom_loader. A queue-based reference model builds
// the full expected output sequence of a stream whenever a request is
// accepted, computing each table entry directly as a sum of selected
// coefficients; a compare process checks every DUT output against it on each
// falling clock edge. Directed sections pin literal values and timing.
// -----------------------------------------------------------------------------
module tb_da_rom_loader;

  logic               clk;
  logic               resetn;
  logic signed [15:0] coef_in;
  logic [5:0]         coef_addr;
  logic               coef_we;
  logic               load_start;
  logic               abort;
  logic               busy;
  logic               done;
  logic [10:0]        caddr;
  logic signed [19:0] cin;
  logic               cload;
  logic               cvalid;

  int checks;
  int failures;

  typedef struct packed {
    logic               cload;
    logic [10:0]        caddr;
    logic signed [19:0] cin;
    logic               done;
    logic               busy;
  } exp_t;

  exp_t expQ[$];
  exp_t expCur;
  int   coefM [64];

  int firstCload, lastCload, cloadCnt, doneAt, doneCnt, entry1;
  int busyAt2049, busyAt2050, doneSeen, abortAt;
  bit found;

  da_rom_loader #(.COEF_W(16), .OUT_W(20)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .coef_in    (coef_in),
    .coef_addr  (coef_addr),
    .coef_we    (coef_we),
    .load_start (load_start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .caddr      (caddr),
    .cin        (cin),
    .cload      (cload),
    .cvalid     (cvalid)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so a stuck design can never hang the run.
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Table entry straight from its definition: sum of the coefficients of
  // group r whose bit is set in a.
  function automatic int tVal(input int r, input int a);
    int s;
    s = 0;
    for (int b = 0; b < 8; b++) begin
      if (((a >> b) & 1) == 1) s += coefM[8*r + b];
    end
    return s;
  endfunction

  // Reference model. An accepted request queues the whole expected output
  // sequence (2048 entries then a done cycle); each edge pops one item, an
  // abort discards whatever is left. The block is idle exactly when nothing
  // is queued.
  always @(posedge clk or negedge resetn) begin
    bit   wasIdle;
    exp_t rec;
    if (!resetn) begin
      expQ.delete();
      for (int k = 0; k < 64; k++) coefM[k] = 0;
      expCur = '0;
    end else begin
      wasIdle = (expQ.size() == 0);
      if (!wasIdle && abort) begin
        expQ.delete();
        expCur = '0;
      end else begin
        if (wasIdle && coef_we) coefM[coef_addr] = int'(coef_in);
        if (expQ.size() > 0) expCur = expQ.pop_front();
        else expCur = '0;
        if (wasIdle && load_start) begin
          for (int e = 0; e < 2048; e++) begin
            rec.cload = 1'b1;
            rec.caddr = 11'(e);
            rec.cin   = 20'(tVal(e >> 8, e & 255));
            rec.done  = 1'b0;
            rec.busy  = 1'b1;
            expQ.push_back(rec);
          end
          rec = '0;
          rec.done = 1'b1;
          rec.busy = 1'b1;
          expQ.push_back(rec);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Every cycle, away from the active edge, compare all outputs to the model.
  always @(negedge clk) begin
    checkOutput("cmp_cload",  int'(cload),  int'(expCur.cload));
    checkOutput("cmp_cvalid", int'(cvalid), int'(expCur.cload));
    checkOutput("cmp_caddr",  int'(caddr),  int'(expCur.caddr));
    checkOutput("cmp_cin",    int'(cin),    int'(expCur.cin));
    checkOutput("cmp_done",   int'(done),   int'(expCur.done));
    checkOutput("cmp_busy",   int'(busy),   int'(expCur.busy));
  end

  task automatic applyStimulus(input logic ls, input logic ab, input logic we,
                               input logic [5:0] addr, input logic [15:0] data);
    load_start = ls;
    abort      = ab;
    coef_we    = we;
    coef_addr  = addr;
    coef_in    = data;
  endtask

  task automatic writeCoef(input int k, input logic [15:0] v);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'(k), v);
  endtask

  // Request is sampled at the edge after the first negedge; returns at the
  // negedge following that edge with inputs quiet.
  task automatic startStream();
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 16'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'd0);
  endtask

  task automatic waitAddr(input int addr, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < 2200 && !hit; i++) begin
      @(negedge clk);
      if (cload && int'(caddr) == addr) hit = 1'b1;
    end
  endtask

  task automatic waitEntry(input int addr, input int lit, input string name);
    bit hit;
    waitAddr(addr, hit);
    checkOutput({name, "_found"}, int'(hit), 1);
    if (hit) checkOutput(name, int'(cin), lit);
  endtask

  task automatic waitDone(input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 2200 && !hit; i++) begin
      @(negedge clk);
      if (done) hit = 1'b1;
    end
    checkOutput(name, int'(hit), 1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'd0);
    #1 resetn = 1'b0;

    // 1. Reset with random inputs, then a stream of all-zero coefficients.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 6'($urandom), 16'($urandom));
    end
    @(negedge clk);
    checkOutput("rst_busy",  int'(busy),  0);
    checkOutput("rst_cload", int'(cload), 0);
    checkOutput("rst_cin",   int'(cin),   0);
    checkOutput("rst_caddr", int'(caddr), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'd0);
    resetn = 1'b1;
    startStream();
    waitEntry(11'h7FF, 0, "zero_7ff");
    waitDone("zero_done");

    // 2. All coefficients 1: entries equal popcount of the address.
    for (int k = 0; k < 64; k++) writeCoef(k, 16'd1);
    startStream();
    waitEntry(11'h0FF, 8, "pop_0ff");
    waitEntry(11'h1A5, 4, "pop_1a5");
    waitEntry(11'h700, 0, "pop_700");
    waitDone("pop_done");

    // 3. coef[k] = k.
    for (int k = 0; k < 64; k++) writeCoef(k, 16'(k));
    startStream();
    waitEntry(11'h381, 55, "ramp_381");
    waitEntry(11'h7FF, 476, "ramp_7ff");
    waitDone("ramp_done");

    // 4. All coefficients at the negative full-scale value.
    for (int k = 0; k < 64; k++) writeCoef(k, 16'h8000);
    startStream();
    waitEntry(11'h201, -32768, "neg_201");
    waitEntry(11'h2FF, -262144, "neg_2ff");
    waitDone("neg_done");

    // 5. Handshake timing, with an ignored re-request and an ignored write.
    writeCoef(0, 16'd7);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 16'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'd0);
    firstCload = -1; lastCload = -1; cloadCnt = 0; doneAt = -1; doneCnt = 0;
    entry1 = -1; busyAt2049 = -1; busyAt2050 = -1;
    for (int k = 1; k <= 2051; k++) begin
      @(negedge clk);
      if (cload) begin
        cloadCnt++;
        if (firstCload < 0) firstCload = k;
        lastCload = k;
        if (int'(caddr) == 1) entry1 = int'(cin);
      end
      if (done) begin
        doneCnt++;
        doneAt = k;
      end
      if (k == 2049) busyAt2049 = int'(busy);
      if (k == 2050) busyAt2050 = int'(busy);
      applyStimulus(1'(k + 1 == 100), 1'b0, 1'(k + 1 == 50), 6'd0, 16'd999);
    end
    checkOutput("hs_first_cload", firstCload, 1);
    checkOutput("hs_last_cload",  lastCload,  2048);
    checkOutput("hs_cload_count", cloadCnt,   2048);
    checkOutput("hs_done_at",     doneAt,     2049);
    checkOutput("hs_done_count",  doneCnt,    1);
    checkOutput("hs_busy_2049",   busyAt2049, 1);
    checkOutput("hs_busy_2050",   busyAt2050, 0);
    checkOutput("hs_entry1",      entry1,     7);
    startStream();
    waitEntry(11'h001, 7, "readback_001");
    waitDone("readback_done");

    // 6a. Abort while entry 100 is on the outputs, then restart from 0.
    startStream();
    waitAddr(100, found);
    checkOutput("abort_reach_100", int'(found), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 6'd0, 16'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'd0);
    checkOutput("abort_cload", int'(cload), 0);
    checkOutput("abort_busy",  int'(busy),  0);
    checkOutput("abort_done",  int'(done),  0);
    doneSeen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("abort_no_done", doneSeen, 0);
    startStream();
    @(negedge clk);
    checkOutput("restart_cload", int'(cload), 1);
    checkOutput("restart_caddr", int'(caddr), 0);

    // 6b. Reset in the middle of that stream clears outputs and coefficients.
    waitAddr(500, found);
    checkOutput("mrst_reach_500", int'(found), 1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("mrst_cload",  int'(cload),  0);
    checkOutput("mrst_cvalid", int'(cvalid), 0);
    checkOutput("mrst_caddr",  int'(caddr),  0);
    checkOutput("mrst_cin",    int'(cin),    0);
    checkOutput("mrst_busy",   int'(busy),   0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    startStream();
    waitEntry(11'h2FF, 0, "mrst_2ff");
    waitEntry(11'h7FF, 0, "mrst_7ff");
    waitDone("mrst_done");

    // 7. Randomised coefficients with noise on the control inputs; one run
    //    aborts mid-stream and one aborts in the done cycle.
    for (int it = 0; it < 3; it++) begin
      for (int w = 0; w < int'($urandom_range(10, 63)); w++) begin
        writeCoef(int'($urandom_range(0, 63)), 16'($urandom));
      end
      abortAt = (it == 1) ? int'($urandom_range(10, 2000)) : ((it == 2) ? 2049 : 0);
      startStream();
      for (int k = 1; k <= 2060; k++) begin
        @(negedge clk);
        applyStimulus(1'($urandom_range(0, 49) == 0), 1'(k + 1 == abortAt),
                      1'($urandom_range(0, 19) == 0), 6'($urandom), 16'($urandom));
      end
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'd0);
      found = 1'b0;
      for (int i = 0; i < 2300 && !found; i++) begin
        @(negedge clk);
        if (expQ.size() == 0 && !busy && !done) found = 1'b1;
      end
      checkOutput("rand_drain", int'(found), 1);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
